// File: rtl/arith_pipe_cfg.sv
// rtl/arith_pipe_cfg.sv - three-stage handshaked fixed-point exp/normalise/activation/aggregate pipeline
module arith_pipe_cfg #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LUT_AW = 8,
    parameter int NUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_psum,
    input  logic [1:0]        in_mode,
    input  logic              in_last,
    input  logic              lut_we,
    input  logic [1:0]        lut_sel,
    input  logic [LUT_AW-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_mode,
    output logic [DATA_W-1:0] sum_q,
    output logic              sum_done
);

    localparam int LUT_N  = 1 << LUT_AW;
    localparam int WIDX_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NUM_W - 1);

    localparam logic [1:0] MODE_EXP  = 2'd0;
    localparam logic [1:0] MODE_NORM = 2'd1;
    localparam logic [1:0] MODE_ACT  = 2'd2;
    localparam logic [1:0] MODE_AGG  = 2'd3;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Fixed-point multiply: full-width product, arithmetic shift back to Q format, clamp.
    function automatic logic [DATA_W-1:0] sat_mul(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        p = p >>> FRAC_W;
        if ((&p[2*DATA_W-1:DATA_W-1]) || !(|p[2*DATA_W-1:DATA_W-1]))
            return p[DATA_W-1:0];
        else if (p[2*DATA_W-1])
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

    // Add with one guard bit; a disagreement between the top two bits means overflow.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] == s[DATA_W-1])
            return s[DATA_W-1:0];
        else if (s[DATA_W])
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

    // Lookup tables and gating-weight buffer; contents survive reset.
    logic [DATA_W-1:0] exp_lut [LUT_N];
    logic [DATA_W-1:0] rcp_lut [LUT_N];
    logic [DATA_W-1:0] act_lut [LUT_N];
    logic [DATA_W-1:0] wbuf    [NUM_W];

    logic [WIDX_W-1:0] widx;
    logic [WIDX_W-1:0] aidx;
    logic              acc_fresh;

    // Stage 1: captured input beat, tables read combinationally during this stage.
    logic              s1_valid;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] s1_psum;
    logic              s1_last;
    logic [DATA_W-1:0] s1_a;

    // Stage 2: looked-up operand and multiplier inputs.
    logic              s2_valid;
    logic [1:0]        s2_mode;
    logic [DATA_W-1:0] s2_a;
    logic [DATA_W-1:0] s2_b;
    logic [DATA_W-1:0] s2_psum;
    logic              s2_last;
    logic [DATA_W-1:0] s2_val;

    // Stage 3: product (or pass-through value) awaiting the final add.
    logic              s3_valid;
    logic [1:0]        s3_mode;
    logic [DATA_W-1:0] s3_val;
    logic [DATA_W-1:0] s3_psum;
    logic              s3_last;
    logic [DATA_W-1:0] s3_res;

    logic              en;
    logic              drain;
    logic              accept;
    logic [DATA_W-1:0] rcp_shift;
    logic [LUT_AW-1:0] rcp_idx;
    logic [LUT_AW-1:0] s1_idx;
    logic [WIDX_W-1:0] widx_next;
    logic [WIDX_W-1:0] aidx_next;

    // A mode change waits until the pipe is free of the other mode, so NORM sees the
    // final sum and AGG sees the written weights.
    always_comb begin
        en     = !out_valid || out_ready;
        drain  = in_valid && ((s1_valid && (s1_mode != in_mode)) ||
                              (s2_valid && (s2_mode != in_mode)) ||
                              (s3_valid && (s3_mode != in_mode)));
        in_ready = en && !lut_we && !drain;
        accept   = in_valid && in_ready;
    end

    // Reciprocal index from the integer part of the sum, clamped to the table range.
    always_comb begin
        rcp_shift = sum_q >> FRAC_W;
        if (sum_q[DATA_W-1])
            rcp_idx = '0;
        else if ((rcp_shift >> LUT_AW) != '0)
            rcp_idx = '1;
        else
            rcp_idx = rcp_shift[LUT_AW-1:0];
    end

    // Stage 1 operand selection per mode.
    always_comb begin
        s1_idx = s1_data[DATA_W-1 -: LUT_AW];
        s1_a   = '0;
        case (s1_mode)
            MODE_EXP:  s1_a = exp_lut[s1_idx];
            MODE_NORM: s1_a = rcp_lut[rcp_idx];
            MODE_ACT:  s1_a = act_lut[s1_idx];
            default:   s1_a = wbuf[aidx];
        endcase
    end

    // Stage 2 multiply for the modes that scale by the operand.
    always_comb begin
        s2_val = s2_a;
        if ((s2_mode == MODE_NORM) || (s2_mode == MODE_AGG))
            s2_val = sat_mul($signed(s2_a), $signed(s2_b));
    end

    // Stage 3 add of the partial sum for aggregation beats.
    always_comb begin
        s3_res = s3_val;
        if (s3_mode == MODE_AGG)
            s3_res = sat_add(s3_psum, s3_val);
    end

    // Wrapping index increments for the weight buffer.
    always_comb begin
        widx_next = (widx == WIDX_LAST) ? '0 : widx + 1'b1;
        aidx_next = (aidx == WIDX_LAST) ? '0 : aidx + 1'b1;
    end

    // Runtime LUT loading; selector value 3 writes nothing.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            case (lut_sel)
                2'd0:    exp_lut[lut_addr] <= lut_wdata;
                2'd1:    rcp_lut[lut_addr] <= lut_wdata;
                2'd2:    act_lut[lut_addr] <= lut_wdata;
                default: ;
            endcase
        end
    end

    // Normalised weights are stored as the NORM beat leaves stage 3.
    always_ff @(posedge clk) begin
        if (rst_n && en && s3_valid && (s3_mode == MODE_NORM))
            wbuf[widx] <= s3_val;
    end

    // Datapath registers advance with the pipe; their validity is tracked separately.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_mode <= in_mode;
            s1_data <= in_data;
            s1_psum <= in_psum;
            s1_last <= in_last;
            s2_mode <= s1_mode;
            s2_a    <= s1_a;
            s2_b    <= s1_data;
            s2_psum <= s1_psum;
            s2_last <= s1_last;
            s3_mode <= s2_mode;
            s3_val  <= s2_val;
            s3_psum <= s2_psum;
            s3_last <= s2_last;
        end
    end

    // Stage valids, output register, accumulator and buffer indices.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= 2'd0;
            sum_q     <= '0;
            sum_done  <= 1'b0;
            acc_fresh <= 1'b1;
            widx      <= '0;
            aidx      <= '0;
        end else if (en) begin
            s1_valid  <= accept;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid && (s3_mode != MODE_EXP);
            if (s3_valid && (s3_mode != MODE_EXP)) begin
                out_data <= s3_res;
                out_mode <= s3_mode;
            end
            if (s3_valid && (s3_mode == MODE_EXP)) begin
                if (sum_done || acc_fresh) begin
                    sum_q     <= s3_val;
                    widx      <= '0;
                    acc_fresh <= 1'b0;
                end else begin
                    sum_q <= sat_add(sum_q, s3_val);
                end
                sum_done <= s3_last;
            end
            if (s3_valid && (s3_mode == MODE_NORM)) begin
                widx <= widx_next;
                aidx <= '0;
            end
            if (s1_valid && (s1_mode == MODE_AGG))
                aidx <= s1_last ? '0 : aidx_next;
        end
    end

endmodule

// File: tb/tb_arith_pipe_cfg.sv
// tb/tb_arith_pipe_cfg.sv - directed scoreboard bench for arith_pipe_cfg
module tb_arith_pipe_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_psum;
    logic [1:0]  in_mode;
    logic        in_last;
    logic        lut_we;
    logic [1:0]  lut_sel;
    logic [7:0]  lut_addr;
    logic [15:0] lut_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_mode;
    logic [15:0] sum_q;
    logic        sum_done;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q [$];

    always #5 clk = ~clk;

    arith_pipe_cfg #(.DATA_W(16), .FRAC_W(8), .LUT_AW(8), .NUM_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_psum(in_psum),
        .in_mode(in_mode), .in_last(in_last),
        .lut_we(lut_we), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .sum_q(sum_q), .sum_done(sum_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        logic [17:0] e;
        if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_out: observed=%0h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {14'd0, out_mode, out_data}, {14'd0, e});
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic lut_wr(input logic [1:0] sel, input logic [7:0] addr, input logic [15:0] data);
        lut_we = 1'b1; lut_sel = sel; lut_addr = addr; lut_wdata = data;
        #1;
        check("lut_wr_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        lut_we = 1'b0;
    endtask

    task automatic send(input logic [1:0] mode, input logic [15:0] data, input logic [15:0] psum,
                        input logic last, input logic [15:0] expv, output int stalls);
        in_valid = 1'b1; in_mode = mode; in_data = data; in_psum = psum; in_last = last;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 40) begin
            stalls++;
            cyc();
            #1;
        end
        check("accept", {31'd0, in_ready}, 32'd1);
        if (in_ready && mode != 2'd0) exp_q.push_back({mode, expv});
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic flush();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
        check("flush_empty", exp_q.size(), 0);
    endtask

    initial begin
        int st;
        logic [15:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_psum = '0; in_mode = '0; in_last = 1'b0;
        lut_we = 1'b0; lut_sel = '0; lut_addr = '0; lut_wdata = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_mode", {30'd0, out_mode}, 32'd0);
        check("rst_sum_q", {16'd0, sum_q}, 32'd0);
        check("rst_sum_done", {31'd0, sum_done}, 32'd0);
        rst_n = 1'b1;
        cyc();

        lut_wr(2'd2, 8'h02, 16'h1234);
        lut_wr(2'd2, 8'h03, 16'h2345);
        lut_wr(2'd2, 8'h04, 16'h3456);
        lut_wr(2'd2, 8'h05, 16'h4567);
        lut_wr(2'd0, 8'h01, 16'h0100);
        lut_wr(2'd0, 8'h02, 16'h0200);
        lut_wr(2'd1, 8'h03, 16'h0055);

        // ACT with exact three-edge latency
        send(2'd2, 16'h0280, 16'h0000, 1'b0, 16'h1234, st);
        check("act_lat0", {31'd0, out_valid}, 32'd0);
        cyc();
        check("act_lat1", {31'd0, out_valid}, 32'd0);
        cyc();
        check("act_lat2", {31'd0, out_valid}, 32'd0);
        cyc();
        check("act_valid", {31'd0, out_valid}, 32'd1);
        check("act_data", {16'd0, out_data}, 32'h1234);
        check("act_mode", {30'd0, out_mode}, 32'd2);
        flush();

        // Softmax: accumulate, NORM held until the EXP beats leave the pipe
        send(2'd0, 16'h0100, 16'h0000, 1'b0, 16'h0000, st);
        send(2'd0, 16'h0200, 16'h0000, 1'b1, 16'h0000, st);
        send(2'd1, 16'h0100, 16'h0000, 1'b0, 16'h0055, st);
        check("norm_stalls", st, 3);
        check("sm_sum_q", {16'd0, sum_q}, 32'h0300);
        check("sm_sum_done", {31'd0, sum_done}, 32'd1);
        flush();
        send(2'd3, 16'h0100, 16'h0000, 1'b1, 16'h0055, st);
        flush();

        // Second group: wbuf[0]=0x0080, wbuf[1]=0x0100, then aggregation and saturation
        lut_wr(2'd1, 8'h03, 16'h0080);
        send(2'd0, 16'h0100, 16'h0000, 1'b0, 16'h0000, st);
        send(2'd0, 16'h0200, 16'h0000, 1'b1, 16'h0000, st);
        send(2'd1, 16'h0100, 16'h0000, 1'b0, 16'h0080, st);
        check("g2_sum_q", {16'd0, sum_q}, 32'h0300);
        send(2'd1, 16'h0200, 16'h0000, 1'b0, 16'h0100, st);
        send(2'd3, 16'h0400, 16'h0100, 1'b0, 16'h0300, st);
        send(2'd3, 16'h0400, 16'h0000, 1'b1, 16'h0400, st);
        send(2'd3, 16'h0400, 16'h0000, 1'b1, 16'h0200, st);
        send(2'd3, 16'h0400, 16'h7F00, 1'b1, 16'h7FFF, st);
        send(2'd3, 16'hFC00, 16'h8100, 1'b1, 16'h8000, st);
        flush();

        // Backpressure: four ACT beats into a stalled sink
        out_ready = 1'b0;
        send(2'd2, 16'h0280, 16'h0000, 1'b0, 16'h1234, st);
        send(2'd2, 16'h0380, 16'h0000, 1'b0, 16'h2345, st);
        send(2'd2, 16'h0480, 16'h0000, 1'b0, 16'h3456, st);
        send(2'd2, 16'h0580, 16'h0000, 1'b0, 16'h4567, st);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        held = out_data;
        idle(5);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_data", {16'd0, out_data}, {16'd0, held});
        check("bp_first", {16'd0, out_data}, 32'h1234);
        out_ready = 1'b1;
        flush();
        idle(4);

        // Reset with EXP beats in flight
        send(2'd0, 16'h0100, 16'h0000, 1'b0, 16'h0000, st);
        send(2'd0, 16'h0200, 16'h0000, 1'b0, 16'h0000, st);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_sum_q", {16'd0, sum_q}, 32'd0);
        check("mr_sum_done", {31'd0, sum_done}, 32'd0);
        idle(4);
        check("mr_discard", {16'd0, sum_q}, 32'd0);
        send(2'd0, 16'h0100, 16'h0000, 1'b1, 16'h0000, st);
        idle(4);
        check("mr_restart_sum", {16'd0, sum_q}, 32'h0100);
        check("mr_restart_done", {31'd0, sum_done}, 32'd1);
        send(2'd2, 16'h0280, 16'h0000, 1'b0, 16'h1234, st);
        flush();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_pipe_cfg.md
# arith_pipe_cfg

Parametrised, handshaked arithmetic pipeline for the MoE output path: it applies LUT exp with accumulation, reciprocal-normalise, LUT activation and weighted aggregation to a stream of fixed-point beats from the output collector. It extends the fixed-mode FP16 unit with configurable width and depth, runtime-loadable LUTs, valid/ready backpressure, saturating arithmetic and explicit group delimiting.

## Interface
- DATA_W, 16, signed two's-complement data width.
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
- LUT_AW, 8, LUT address width; each LUT holds 2^LUT_AW x DATA_W entries.
- NUM_W, 8, gating-weight buffer depth; power of two.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  operand.
- in_psum  in  DATA_W  partial sum; used in mode 3 only.
- in_mode  in  2  0 EXP_ACC, 1 NORM, 2 ACT, 3 AGG.
- in_last  in  1  last beat of a group (modes 0 and 3).
- lut_we  in  1  LUT write strobe.
- lut_sel  in  2  0 exp, 1 reciprocal, 2 activation; 3 ignored.
- lut_addr  in  LUT_AW  LUT write address.
- lut_wdata  in  DATA_W  LUT write data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  result.
- out_mode  out  2  mode of the result beat.
- sum_q  out  DATA_W  current exp accumulator.
- sum_done  out  1  accumulator holds a closed group sum.

## Operation
- LUT index for modes 0 and 2: idx = in_data[DATA_W-1 -: LUT_AW].
- Reciprocal index: rcp_idx = sum_q >> FRAC_W, saturated to 2^LUT_AW-1; negative sum gives 0.
- mul(a,b) = (a*b) >>> FRAC_W, computed at full 2*DATA_W width, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- add(a,b) is computed at DATA_W+1 bits, then saturated the same way.
- Mode 0 EXP_ACC:
  - e = exp_lut[idx].
  - If sum_done=1 or this is the first beat since reset, acc = e, widx is cleared to 0, and sum_done is cleared. Otherwise acc = add(acc, e).
  - in_last sets sum_done. No output beat is produced.
- Mode 1 NORM:
  - w = mul(rcp_lut[rcp_idx], in_data).
  - Write wbuf[widx] = w; widx++ mod NUM_W; aidx is cleared to 0.
  - Output w.
- Mode 2 ACT: output act_lut[idx].
- Mode 3 AGG:
  - Output add(in_psum, mul(wbuf[aidx], in_data)).
  - aidx++ mod NUM_W; in_last clears aidx to 0 after the beat.
- LUT write: when lut_we=1, lut_sel selects the table and the entry updates at the edge. A beat accepted in a later cycle reads the new value.
- LUT and wbuf contents are not affected by rst_n.

## Timing
- Three stages:
  - S1: LUT and wbuf read.
  - S2: multiply.
  - S3: add, saturate, output register.
- A beat accepted at edge T is presented with out_valid=1 after edge T+3.
- Stage enable: en = !out_valid || out_ready. All stages and accumulator/index updates advance only when en=1.
- in_ready = en && !lut_we && !drain. in_ready stays low during a LUT write cycle.
- drain = 1 when in_valid=1, in_mode differs from the mode of any beat in S1..S3, and that pipeline is non-empty.
  - Consequence: NORM after EXP_ACC sees the final sum, and AGG after NORM sees the written wbuf.
- Mode 0 beats occupy slots but never raise out_valid. acc updates when the beat leaves S3 with en=1.
- out_valid/out_data hold stable while out_ready=0. Ordering is strictly FIFO.
- widx and aidx wrap silently at NUM_W.
- Reset values, effective at the edge with rst_n=0:
  - out_valid=0, out_data=0, out_mode=0.
  - sum_q=0, sum_done=0, widx=0, aidx=0.
  - All stage valids 0; in-flight beats are discarded.
- in_ready may be 1 in the first cycle after reset deasserts.

## Test plan
- ACT: write act_lut[0x02]=0x1234; send mode 2, in_data=0x0280 at edge T -> out_valid after T+3 with out_data=0x1234, out_mode=2.
- Softmax: exp_lut[1]=0x0100, exp_lut[2]=0x0200, rcp_lut[3]=0x0055. Send mode 0 beats 0x0100, then 0x0200 with in_last, then NORM in_data=0x0100.
  - sum_q=0x0300 and sum_done=1.
  - NORM held off (in_ready=0) until both EXP beats have drained.
  - Output 0x0055; wbuf[0]=0x0055.
- AGG: wbuf[0]=0x0080. Mode 3 with in_data=0x0400, in_psum=0x0100 -> 0x0300.
  - Next beat reads wbuf[1].
  - After an in_last beat, the following AGG reads wbuf[0].
- Saturation: AGG with in_psum=0x7F00 and product 0x0200 -> 0x7FFF. With in_psum=0x8100 and product 0xFE00 -> 0x8000.
- Backpressure: four ACT beats back-to-back with out_ready=0 for 6 cycles -> in_ready drops after the pipe fills. All four results arrive in order with no loss or duplication.
- Reset mid-group: two EXP beats in flight, then rst_n=0 for one cycle -> out_valid=0 and sum_q=0. The next EXP beat 0x0100 restarts acc at exp_lut[1].
